// File: rtl/ffchain_bist_pkg.sv
// Shared types and constants for the flop-chain BIST sequencer.
`timescale 1ns/1ps
package ffchain_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    RUN,
    DRAIN,
    FIN
  } state_e;

  localparam int                LFSR_W     = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;  // bits 7,5,4,3
  localparam int                ERR_W      = 8;
  localparam int                IDX_W      = 16;
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
  localparam logic [IDX_W-1:0]  FIRST_NONE = 16'hFFFF;

  // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ffchain_bist_lfsr.sv
// 8-bit Fibonacci LFSR pattern source with synchronous load and step enable.
`timescale 1ns/1ps
module ffchain_bist_lfsr
  import ffchain_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic msb_o
);

  logic [LFSR_W-1:0] state_q;

  // Load wins over step so a new test always starts from SEED.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    if (rst_i || load_i) begin
      state_q <= SEED;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign msb_o = state_q[LFSR_W-1];

endmodule

// File: rtl/ffchain_bist.sv
// BIST sequencer for a negedge flop chain: drives an LFSR stream into the
// chain head, compares the tail against a tagged delay line, reports results.
`timescale 1ns/1ps
module ffchain_bist
  import ffchain_bist_pkg::*;
#(
  parameter int                CHAIN_LEN = 8,
  parameter int                PAT_LEN   = 255,
  parameter logic [LFSR_W-1:0] SEED      = 8'hA5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             CHAIN_D,
  input  logic             CHAIN_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [IDX_W-1:0] FIRST_ERR
);

  localparam logic [IDX_W-1:0] CHAIN_LAST = IDX_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] PAT_LAST   = IDX_W'(PAT_LEN - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               busy_q, done_q, pass_q, chain_d_q;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   first_q, first_d;

  // Expected-bit delay line; entry 0 is loaded on the same edge as CHAIN_D,
  // so entry CHAIN_LEN-1 lines up with the chain tail at its sampling edge.
  logic [CHAIN_LEN-1:0] dl_v_q;
  logic [CHAIN_LEN-1:0] dl_b_q;
  logic [IDX_W-1:0]     dl_idx_q [CHAIN_LEN];

  logic             start_acc;
  logic             head_v_d, head_b_d;
  logic [IDX_W-1:0] head_idx_d;
  logic             lfsr_msb;
  logic             mismatch;

  ffchain_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (start_acc),
    .en_i   (head_v_d),
    .msb_o  (lfsr_msb)
  );

  // Next head-of-chain tag and compare/accumulate logic.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    start_acc  = START && (state_q == IDLE || state_q == FIN);
    head_v_d   = (state_q == FLUSH && cnt_q == CHAIN_LAST) ||
                 (state_q == RUN   && cnt_q != PAT_LAST);
    head_b_d   = head_v_d & lfsr_msb;
    head_idx_d = (state_q == RUN) ? cnt_q + IDX_W'(1) : '0;

    mismatch = busy_q && dl_v_q[CHAIN_LEN-1] && (CHAIN_Q != dl_b_q[CHAIN_LEN-1]);
    err_d    = err_q;
    first_d  = first_q;
    if (mismatch) begin
      if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
      if (first_q == FIRST_NONE) first_d = dl_idx_q[CHAIN_LEN-1];
    end
  end

  // Sequencer FSM with registered outputs and result accumulators.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      chain_d_q <= 1'b0;
      err_q     <= '0;
      first_q   <= FIRST_NONE;
    end else begin
      chain_d_q <= head_b_d;
      err_q     <= err_d;
      first_q   <= first_d;
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE, FIN: begin
          if (START) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= FIRST_NONE;
          end else begin
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          if (cnt_q == CHAIN_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        RUN: begin
          if (cnt_q == PAT_LAST) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == CHAIN_LAST) begin
            state_q <= FIN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // The final compare lands on this same edge, so use err_d.
            pass_q  <= (err_d == '0);
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay-line valid bits: cleared on reset so stale tags are never compared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dl_v_q <= '0;
    end else if (busy_q) begin
      dl_v_q <= (dl_v_q << 1) | CHAIN_LEN'(head_v_d);
    end
  end

  // Delay-line payload shift.
  always_ff @(posedge CLK) begin
    // NOTE: payload storage has no reset; its valid bit alone decides whether it is used.
    if (busy_q) begin
      dl_b_q      <= (dl_b_q << 1) | CHAIN_LEN'(head_b_d);
      dl_idx_q[0] <= head_idx_d;
      for (int i = CHAIN_LEN - 1; i > 0; i--) begin
        dl_idx_q[i] <= dl_idx_q[i-1];
      end
    end
  end

  assign CHAIN_D   = chain_d_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERR_CNT   = err_q;
  assign FIRST_ERR = first_q;

endmodule

// File: tb/tb_ffchain_bist.sv
// Scoreboard bench: each started test pushes its expected result; a monitor
// pops and compares on every DONE pulse. Chains are modelled as negedge flops.
`timescale 1ns/1ps
module tb_ffchain_bist;

  localparam int CL = 8;

  typedef struct {
    int          busy_len;
    logic [7:0]  err;
    logic [15:0] first;
    logic        pass;
    string       name;
  } exp_t;

  typedef enum int {M_NONE, M_FLIP37, M_STUCK0} mode_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic chain_d_a, chain_q_a, busy_a, done_a, pass_a;
  logic chain_d_b, chain_q_b, busy_b, done_b, pass_b;
  logic [7:0]  err_a, err_b;
  logic [15:0] first_a, first_b;

  int    n_vec = 0, n_err = 0;
  int    cyc = 0, start_cyc = 0;
  mode_e mode = M_NONE;
  exp_t  q_a[$], q_b[$];
  exp_t  e_a, e_b;
  int    blen_a = 0, blen_b = 0, dones_a = 0, dones_before = 0;

  ffchain_bist dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .CHAIN_D(chain_d_a), .CHAIN_Q(chain_q_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a), .FIRST_ERR(first_a)
  );

  ffchain_bist #(.PAT_LEN(300)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .CHAIN_D(chain_d_b), .CHAIN_Q(chain_q_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b), .FIRST_ERR(first_b)
  );

  // Cycle counter and negedge flop-chain models.
  logic [CL-1:0] ch_a, ch_b;
  logic          flip_a;
  always @(posedge clk) cyc <= cyc + 1;
  assign flip_a = (mode == M_FLIP37) && (cyc == start_cyc + CL + 37);
  always @(negedge clk) ch_a <= {ch_a[CL-2:0], chain_d_a ^ flip_a};
  always @(negedge clk) ch_b <= {ch_b[CL-2:0], chain_d_b};
  assign chain_q_a = (mode == M_STUCK0) ? 1'b0 : ch_a[CL-1];
  assign chain_q_b = ~ch_b[CL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor for dut_a.
  always @(negedge clk) begin
    if (rst) begin
      blen_a = 0;
    end else begin
      if (busy_a) blen_a++;
      if (done_a) begin
        dones_a++;
        if (q_a.size() == 0) begin
          fail_now("unexpected_done_a", "got DONE=1, want no DONE (nothing outstanding)");
        end else begin
          e_a = q_a.pop_front();
          check({e_a.name, "_busy_len"}, blen_a, e_a.busy_len);
          check({e_a.name, "_busy_at_done"}, {31'd0, busy_a}, 32'd0);
          check({e_a.name, "_err_cnt"}, {24'd0, err_a}, {24'd0, e_a.err});
          check({e_a.name, "_first_err"}, {16'd0, first_a}, {16'd0, e_a.first});
          check({e_a.name, "_pass"}, {31'd0, pass_a}, {31'd0, e_a.pass});
        end
        blen_a = 0;
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (rst) begin
      blen_b = 0;
    end else begin
      if (busy_b) blen_b++;
      if (done_b) begin
        if (q_b.size() == 0) begin
          fail_now("unexpected_done_b", "got DONE=1, want no DONE (nothing outstanding)");
        end else begin
          e_b = q_b.pop_front();
          check({e_b.name, "_busy_len"}, blen_b, e_b.busy_len);
          check({e_b.name, "_err_cnt"}, {24'd0, err_b}, {24'd0, e_b.err});
          check({e_b.name, "_first_err"}, {16'd0, first_b}, {16'd0, e_b.first});
          check({e_b.name, "_pass"}, {31'd0, pass_b}, {31'd0, e_b.pass});
        end
        blen_b = 0;
      end
    end
  end

  // Caller sits at a negedge; START is sampled at the following posedge.
  task automatic launch_a();
    start_a = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int max_cyc, input string name);
    int k = 0;
    while (!done_a && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (!done_a) fail_now({name, "_timeout"}, "got no DONE within budget, want DONE");
  endtask

  task automatic wait_done_b(input int max_cyc, input string name);
    int k = 0;
    while (!done_b && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (!done_b) fail_now({name, "_timeout"}, "got no DONE within budget, want DONE");
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"},    {31'd0, busy_a},    32'd0);
    check({tag, "_done"},    {31'd0, done_a},    32'd0);
    check({tag, "_pass"},    {31'd0, pass_a},    32'd0);
    check({tag, "_err_cnt"}, {24'd0, err_a},     32'd0);
    check({tag, "_first"},   {16'd0, first_a},   32'h0000_FFFF);
    check({tag, "_chain_d"}, {31'd0, chain_d_a}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("reset_a");
    check("reset_b_busy",  {31'd0, busy_b},  32'd0);
    check("reset_b_first", {16'd0, first_b}, 32'h0000_FFFF);
    rst = 1'b0;
    @(negedge clk);

    // Clean loopback: 8+255+8 busy cycles, no errors.
    q_a.push_back('{271, 8'd0, 16'hFFFF, 1'b1, "pass"});
    launch_a();
    wait_done_a(400, "pass");

    // Back-to-back start in the DONE cycle, with index 37 inverted.
    mode = M_FLIP37;
    q_a.push_back('{271, 8'd1, 16'd37, 1'b0, "flip37"});
    launch_a();
    wait_done_a(400, "flip37");

    // Stuck-at-0 tail: 128 ones in a full LFSR period; seed MSB is 1.
    mode = M_STUCK0;
    q_a.push_back('{271, 8'd128, 16'd0, 1'b0, "stuck0"});
    launch_a();
    wait_done_a(400, "stuck0");

    // Reset in RUN cycle 50 (errors already accumulating) aborts silently.
    @(negedge clk);
    launch_a();
    repeat (CL + 50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("abort");
    rst = 1'b0;
    dones_before = dones_a;
    repeat (300) @(negedge clk);
    check("abort_no_done", dones_a, dones_before);

    // Full passing test after the abort.
    mode = M_NONE;
    q_a.push_back('{271, 8'd0, 16'hFFFF, 1'b1, "after_abort"});
    launch_a();
    wait_done_a(400, "after_abort");

    // START pulses while busy are ignored.
    @(negedge clk);
    q_a.push_back('{271, 8'd0, 16'hFFFF, 1'b1, "start_spam"});
    launch_a();
    for (int i = 0; i < 30; i++) begin
      repeat (3) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done_a(400, "start_spam");

    // Inverted chain with PAT_LEN=300: count saturates, first error at 0.
    @(negedge clk);
    q_b.push_back('{316, 8'd255, 16'd0, 1'b0, "inv300"});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done_b(500, "inv300");

    repeat (5) @(negedge clk);
    check("queue_a_drained", q_a.size(), 32'd0);
    check("queue_b_drained", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
